// File: rtl/mem_channel_model.sv
// Multi-channel shared memory model: each read/write channel runs an independent
// accept/wait/respond FSM with a fixed latency, plus a backdoor init write port.
module mem_channel_model #(
  parameter int unsigned ADDR_BITS    = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned WRITE_EN     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] read_valid,
  input  logic [ADDR_BITS-1:0]    read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] read_ready,
  output logic [DATA_BITS-1:0]    read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] write_valid,
  input  logic [ADDR_BITS-1:0]    write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] write_ready,
  input  logic                    init_write_enable,
  input  logic [ADDR_BITS-1:0]    init_address,
  input  logic [DATA_BITS-1:0]    init_data,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count
);

  localparam int unsigned NumFsm  = 2 * NUM_CHANNELS;
  localparam int unsigned Depth   = 1 << ADDR_BITS;
  localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [DATA_BITS-1:0] mem [Depth];
  state_e               st_q [NumFsm];
  state_e               st_d [NumFsm];
  logic [3:0]           cnt_q [NumFsm];
  logic [3:0]           cnt_d [NumFsm];
  logic [ADDR_BITS-1:0] addr_q [NumFsm];
  logic [ADDR_BITS-1:0] addr_eff [NumFsm];
  logic [DATA_BITS-1:0] wdata_q [NUM_CHANNELS];
  logic [DATA_BITS-1:0] wdata_eff [NUM_CHANNELS];
  logic [NumFsm-1:0]    valid;
  logic [NumFsm-1:0]    enter_resp;

  // FSM index i < NUM_CHANNELS is a read channel, the rest are write channels.
  // Write FSMs never see a request in a read-only memory.
  assign valid = {write_valid & {NUM_CHANNELS{WRITE_EN != 0}}, read_valid};

  function automatic logic [31:0] sat_add(logic [31:0] base, logic [NUM_CHANNELS-1:0] hits);
    logic [32:0] sum;
    sum = {1'b0, base};
    for (int i = 0; i < NUM_CHANNELS; i++) sum = sum + 33'(hits[i]);
    return sum[32] ? '1 : sum[31:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NumFsm; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      unique case (st_q[i])
        StIdle: begin
          if (valid[i]) begin
            cnt_d[i] = CntInit;
            st_d[i]  = (LATENCY == 1) ? StResp : StWait;
          end
        end
        StWait: begin
          if (!valid[i])              st_d[i] = StIdle;
          else if (cnt_q[i] == 4'd1)  st_d[i] = StResp;
          else                        cnt_d[i] = cnt_q[i] - 4'd1;
        end
        StResp:  st_d[i] = StIdle;
        default: st_d[i] = StIdle;
      endcase
      enter_resp[i] = (st_d[i] == StResp) && !reset;
    end
  end

  // In IDLE the live inputs are used so a LATENCY=1 response sees the request directly.
  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      addr_eff[c] = (st_q[c] == StIdle) ? read_address[c] : addr_q[c];
      addr_eff[c+NUM_CHANNELS] = (st_q[c+NUM_CHANNELS] == StIdle) ? write_address[c]
                                                                    : addr_q[c+NUM_CHANNELS];
      wdata_eff[c] = (st_q[c+NUM_CHANNELS] == StIdle) ? write_data[c] : wdata_q[c];
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      read_ready[c]  = (st_q[c] == StResp);
      write_ready[c] = (st_q[c+NUM_CHANNELS] == StResp);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumFsm; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumFsm; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_q  <= addr_eff;
    wdata_q <= wdata_eff;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) read_data[c] <= '0;
      read_count  <= '0;
      write_count <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (enter_resp[c]) read_data[c] <= mem[addr_eff[c]];
      end
      read_count  <= sat_add(read_count, enter_resp[NUM_CHANNELS-1:0]);
      write_count <= sat_add(write_count, enter_resp[NumFsm-1:NUM_CHANNELS]);
    end
  end

  // Later assignments win: init loses to any channel, lower channels lose to higher ones.
  always_ff @(posedge clk) begin
    if (init_write_enable) mem[init_address] <= init_data;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (enter_resp[c+NUM_CHANNELS]) mem[addr_eff[c+NUM_CHANNELS]] <= wdata_eff[c];
    end
  end

endmodule

// File: tb/tb_mem_channel_model.sv
// Scoreboard bench: dut_a is a 4-channel LATENCY=3 RAM, dut_b a 1-channel LATENCY=1
// 16-bit read-only memory.
module tb_mem_channel_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut_a signals
  logic       a_reset, a_iwe;
  logic [3:0] a_rv, a_rr, a_wv, a_wr;
  logic [7:0] a_ra [4];
  logic [7:0] a_rdata [4];
  logic [7:0] a_wa [4];
  logic [7:0] a_wd [4];
  logic [7:0] a_ia, a_id;
  logic [31:0] a_rcnt, a_wcnt;

  // dut_b signals
  logic        b_reset, b_iwe;
  logic [0:0]  b_rv, b_rr, b_wv, b_wr;
  logic [7:0]  b_ra [1];
  logic [15:0] b_rdata [1];
  logic [7:0]  b_wa [1];
  logic [15:0] b_wd [1];
  logic [7:0]  b_ia;
  logic [15:0] b_id;
  logic [31:0] b_rcnt, b_wcnt;

  mem_channel_model #(
    .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4), .LATENCY(3), .WRITE_EN(1)
  ) dut_a (
    .clk(clk), .reset(a_reset),
    .read_valid(a_rv), .read_address(a_ra), .read_ready(a_rr), .read_data(a_rdata),
    .write_valid(a_wv), .write_address(a_wa), .write_data(a_wd), .write_ready(a_wr),
    .init_write_enable(a_iwe), .init_address(a_ia), .init_data(a_id),
    .read_count(a_rcnt), .write_count(a_wcnt)
  );

  mem_channel_model #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .LATENCY(1), .WRITE_EN(0)
  ) dut_b (
    .clk(clk), .reset(b_reset),
    .read_valid(b_rv), .read_address(b_ra), .read_ready(b_rr), .read_data(b_rdata),
    .write_valid(b_wv), .write_address(b_wa), .write_data(b_wd), .write_ready(b_wr),
    .init_write_enable(b_iwe), .init_address(b_ia), .init_data(b_id),
    .read_count(b_rcnt), .write_count(b_wcnt)
  );

  typedef struct {
    int          dut;
    bit          wr;
    int          ch;
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int a_rd_done = 0, a_wr_done = 0, b_rd_done = 0, b_wr_done = 0;

  task automatic expect_resp(input int dut, input bit wr, input int ch,
                             input logic [15:0] data, input int due);
    exp_t e;
    e.dut = dut; e.wr = wr; e.ch = ch; e.data = data; e.due = due;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_pop(input int dut, input bit wr, input int ch, input logic [15:0] act);
    int idx = -1;
    for (int i = 0; i < sb.size(); i++) begin
      if (idx < 0 && sb[i].dut == dut && sb[i].wr == wr && sb[i].ch == ch) idx = i;
    end
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL unexpected_ready dut%0d wr=%0b ch%0d: pulse at cycle %0d, required none",
               dut, wr, ch, cyc);
    end else begin
      if (sb[idx].due != cyc || (!wr && act !== sb[idx].data)) begin
        errors++;
        $display("FAIL response dut%0d wr=%0b ch%0d: got data 0x%0h at cycle %0d, required 0x%0h at cycle %0d",
                 dut, wr, ch, act, cyc, sb[idx].data, sb[idx].due);
      end
      if (dut == 0 && !wr) a_rd_done++;
      if (dut == 0 && wr)  a_wr_done++;
      if (dut == 1 && !wr) b_rd_done++;
      if (dut == 1 && wr)  b_wr_done++;
      sb.delete(idx);
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (a_reset) begin a_rd_done = 0; a_wr_done = 0; end
    if (b_reset) begin b_rd_done = 0; b_wr_done = 0; end
    for (int c = 0; c < 4; c++) if (a_rr[c] === 1'b1) check_pop(0, 1'b0, c, {8'h00, a_rdata[c]});
    for (int c = 0; c < 4; c++) if (a_wr[c] === 1'b1) check_pop(0, 1'b1, c, 16'h0);
    if (b_rr[0] === 1'b1) check_pop(1, 1'b0, 0, b_rdata[0]);
    if (b_wr[0] === 1'b1) check_pop(1, 1'b1, 0, 16'h0);
    if (|a_rr) chk("a_read_count", a_rcnt, a_rd_done);
    if (|a_wr) chk("a_write_count", a_wcnt, a_wr_done);
    if (|b_rr) chk("b_read_count", b_rcnt, b_rd_done);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-channel read on dut_a, valid held until the response edge.
  task automatic rd_a(input int ch, input logic [7:0] addr, input logic [7:0] exp);
    int k;
    k = cyc;
    a_rv[ch] = 1'b1;
    a_ra[ch] = addr;
    expect_resp(0, 1'b0, ch, {8'h00, exp}, k + 3);
    repeat (3) tick();
    a_rv[ch] = 1'b0;
    tick();
  endtask

  logic [7:0]  a_ld_addr [4] = '{8'd5, 8'd8, 8'd16, 8'd20};
  logic [7:0]  a_ld_data [4] = '{8'h2A, 8'h05, 8'hAA, 8'h77};

  initial begin
    int k;
    a_reset = 1'b1; a_iwe = 1'b0; a_ia = '0; a_id = '0; a_rv = '0; a_wv = '0;
    b_reset = 1'b1; b_iwe = 1'b0; b_ia = '0; b_id = '0; b_rv = '0; b_wv = '0;
    for (int c = 0; c < 4; c++) begin a_ra[c] = '0; a_wa[c] = '0; a_wd[c] = '0; end
    b_ra[0] = '0; b_wa[0] = '0; b_wd[0] = '0;
    tick();

    // Backdoor loads while reset is held
    a_iwe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_ia = a_ld_addr[i];
      a_id = a_ld_data[i];
      tick();
    end
    a_iwe = 1'b0;
    b_iwe = 1'b1; b_ia = 8'h10; b_id = 16'hBEEF; tick();
    b_ia = 8'h11; b_id = 16'h1234; tick();
    b_iwe = 1'b0;
    tick();

    chk("reset_read_ready", {28'h0, a_rr}, 32'h0);
    chk("reset_write_ready", {28'h0, a_wr}, 32'h0);
    chk("reset_read_data", {a_rdata[0], a_rdata[1], a_rdata[2], a_rdata[3]}, 32'h0);
    chk("reset_read_count", a_rcnt, 32'h0);
    chk("reset_write_count", a_wcnt, 32'h0);
    chk("reset_b_read_data", {16'h0, b_rdata[0]}, 32'h0);

    a_reset = 1'b0; b_reset = 1'b0;
    tick();

    // Two reads in parallel; ch1 address changes after acceptance
    k = cyc;
    a_rv[0] = 1'b1; a_ra[0] = 8'd5;
    a_rv[1] = 1'b1; a_ra[1] = 8'd20;
    expect_resp(0, 1'b0, 0, 16'h002A, k + 3);
    expect_resp(0, 1'b0, 1, 16'h0077, k + 3);
    tick();
    a_ra[1] = 8'd5;
    repeat (2) tick();
    a_rv = '0;
    tick();

    // Write ch2 addr 16 = 0x0E; later address/data changes are ignored
    k = cyc;
    a_wv[2] = 1'b1; a_wa[2] = 8'd16; a_wd[2] = 8'h0E;
    expect_resp(0, 1'b1, 2, 16'h0, k + 3);
    tick();
    a_wa[2] = 8'd0; a_wd[2] = 8'hFF;
    repeat (2) tick();
    a_wv = '0;
    tick();
    rd_a(3, 8'd16, 8'h0E);

    // Read aborted in WAIT: no pulse, no count
    a_rv[1] = 1'b1; a_ra[1] = 8'd5;
    tick();
    a_rv[1] = 1'b0;
    repeat (4) tick();
    chk("read_count_after_abort", a_rcnt, 32'd3);

    // Same-edge writes to addr 8 from ch0/ch3 and read from ch1
    k = cyc;
    a_wv[0] = 1'b1; a_wa[0] = 8'd8; a_wd[0] = 8'h11;
    a_wv[3] = 1'b1; a_wa[3] = 8'd8; a_wd[3] = 8'h33;
    a_rv[1] = 1'b1; a_ra[1] = 8'd8;
    expect_resp(0, 1'b0, 1, 16'h0005, k + 3);
    expect_resp(0, 1'b1, 0, 16'h0, k + 3);
    expect_resp(0, 1'b1, 3, 16'h0, k + 3);
    repeat (3) tick();
    a_wv = '0; a_rv = '0;
    tick();
    rd_a(2, 8'd8, 8'h33);

    // Channel write and init write collide on addr 30
    k = cyc;
    a_wv[0] = 1'b1; a_wa[0] = 8'd30; a_wd[0] = 8'h44;
    expect_resp(0, 1'b1, 0, 16'h0, k + 3);
    repeat (2) tick();
    a_iwe = 1'b1; a_ia = 8'd30; a_id = 8'h99;
    tick();
    a_iwe = 1'b0; a_wv = '0;
    tick();
    rd_a(1, 8'd30, 8'h44);
    chk("read_count_total", a_rcnt, 32'd6);
    chk("write_count_total", a_wcnt, 32'd4);

    // Reset during WAIT of a write to addr 5
    a_wv[1] = 1'b1; a_wa[1] = 8'd5; a_wd[1] = 8'hFF;
    tick();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0; a_wv = '0;
    repeat (4) tick();
    chk("post_reset_read_count", a_rcnt, 32'h0);
    chk("post_reset_write_count", a_wcnt, 32'h0);
    chk("post_reset_read_data0", {24'h0, a_rdata[0]}, 32'h0);
    rd_a(0, 8'd5, 8'h2A);
    chk("post_reset_one_read", a_rcnt, 32'd1);

    // Read-only memory: write port held for 10 cycles must do nothing
    b_wv[0] = 1'b1; b_wa[0] = 8'h10; b_wd[0] = 16'hDEAD;
    repeat (10) tick();
    b_wv = '0;
    tick();
    chk("b_write_count", b_wcnt, 32'h0);

    // LATENCY=1 held read: pulses two cycles apart
    k = cyc;
    b_rv[0] = 1'b1; b_ra[0] = 8'h10;
    expect_resp(1, 1'b0, 0, 16'hBEEF, k + 1);
    expect_resp(1, 1'b0, 0, 16'hBEEF, k + 3);
    repeat (4) tick();
    b_rv = '0;
    tick();

    // Valid high across reset release: accepted on the first non-reset edge
    b_reset = 1'b1; b_rv[0] = 1'b1; b_ra[0] = 8'h11;
    repeat (2) tick();
    k = cyc;
    b_reset = 1'b0;
    expect_resp(1, 1'b0, 0, 16'h1234, k + 1);
    tick();
    b_rv = '0;
    repeat (3) tick();
    chk("b_read_count_after_reset", b_rcnt, 32'd1);

    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_channel_model.md
MEM_CHANNEL_MODEL -- requirements
Module: mem_channel_model

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, address width per channel.
REQ-002 SHALL have parameter DATA_BITS, default 8, data word width.
REQ-003 SHALL have parameter NUM_CHANNELS, default 4, number of independent request channels.
REQ-004 SHALL have parameter LATENCY, default 1, cycles from request acceptance to ready pulse; legal range 1..15.
REQ-005 SHALL have parameter WRITE_EN, default 1; 0 means a read-only (program) memory.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports read_valid (input, NUM_CHANNELS), read_address (input, ADDR_BITS x NUM_CHANNELS, unpacked), read_ready (output, NUM_CHANNELS), read_data (output, DATA_BITS x NUM_CHANNELS, unpacked).
REQ-009 SHALL have ports write_valid (input, NUM_CHANNELS), write_address (input, ADDR_BITS x NUM_CHANNELS), write_data (input, DATA_BITS x NUM_CHANNELS), write_ready (output, NUM_CHANNELS).
REQ-010 SHALL have ports init_write_enable (input, 1), init_address (input, ADDR_BITS), init_data (input, DATA_BITS): backdoor load port.
REQ-011 SHALL have ports read_count and write_count, output, 32, completed-transaction counters.

Function
REQ-012 SHALL hold a 2^ADDR_BITS x DATA_BITS array shared by all channels.
REQ-013 Each channel/direction SHALL run its own FSM: IDLE -> WAIT -> RESP -> IDLE.
REQ-014 IDLE: at edge with valid=1, latch address (and write data), load countdown LATENCY-1; go RESP if LATENCY=1, else WAIT.
REQ-015 WAIT: decrement countdown each edge; go RESP at edge where countdown is 1.
REQ-016 Transition into RESP: read channel loads read_data from array at latched address; write channel commits latched data; ready=1 exactly while in RESP (one cycle).
REQ-017 RESP: always return to IDLE next edge; ready falls; read_data holds its value until the next response.
REQ-018 LATENCY=1 timing: valid seen at edge k -> ready high after edge k, low after edge k+1; a still-high valid is re-accepted no earlier than edge k+2.
REQ-019 valid dropped during WAIT SHALL abort: return to IDLE, no ready pulse, no commit, no count.
REQ-020 Address/data changes after acceptance SHALL be ignored (latched values used).
REQ-021 Same-edge read response and write commit to same address: read returns pre-write value.
REQ-022 Multiple channel writes to same address same edge: highest channel index wins.
REQ-023 Channel write and init write to same address same edge: channel write wins.
REQ-024 init_write_enable=1 SHALL write array at that edge regardless of reset.
REQ-025 read_count/write_count SHALL add the number of channels entering RESP that edge; saturate at 2^32-1.
REQ-026 WRITE_EN=0: write FSMs held IDLE, write_ready constant 0, array unchanged by write ports.
REQ-027 Channels SHALL be fully independent; no arbitration stalls.

Reset
REQ-028 reset=1 at an edge SHALL force all FSMs to IDLE, read_ready=0, write_ready=0, read_data=0, both counters=0.
REQ-029 Reset SHALL NOT clear array contents; mid-operation reset cancels pending requests without commit.
REQ-030 Request whose valid is high at the reset-release edge SHALL be accepted no earlier than the following edge.

Verification
REQ-031 LATENCY=1, init addr 5=0x2A, ch0 read addr 5 held -> ready pulse one cycle after valid, read_data=0x2A, read_count=1, re-pulse two cycles later.
REQ-032 LATENCY=4, ch2 write addr 16 data 0x0E -> write_ready exactly 4 cycles after acceptance; array[16]=0x0E; write_count=1.
REQ-033 LATENCY=3, ch1 read valid dropped after 1 cycle -> no ready pulse, read_count stays 0.
REQ-034 ch0 writes 0x11 and ch3 writes 0x33 to addr 8 same edge, ch1 read addr 8 same edge, array previously 0x05 -> array[8]=0x33, ch1 read_data=0x05.
REQ-035 Reset asserted during WAIT of a write, then released -> no commit, ready never pulses, counters 0, previously loaded data intact.
REQ-036 WRITE_EN=0, NUM_CHANNELS=1, ADDR_BITS=8, DATA_BITS=16: write_valid high 10 cycles -> write_ready stays 0, array unchanged; reads return loaded 16-bit words.
